muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the multi-cycle mult and div units for the main control unit.
//  Takes a start request, pulses the selected unit's init, waits for its stop
//  (or div-by-zero / timeout), then loads HI/LO through the high/low muxes.
//  Reports completion or exception back to the control unit.
// PARAMETERS
//  TIMEOUT_CYCLES  40  max WAIT cycles before timeout_exc (must be >= 2)
//  CNT_W           6   width of WAIT counter; 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  op_start     in   1  request from control unit; sampled only in IDLE
//  op_sel       in   1  0 = MULT, 1 = DIV; captured with op_start
//  abort        in   1  cancel current operation
//  mult_stop    in   1  multiplier finished
//  div_stop     in   1  divider finished
//  div_zero     in   1  divider reports divisor == 0
//  mult_init    out  1  one-cycle start pulse to multiplier
//  div_init     out  1  one-cycle start pulse to divider
//  hilo_sel     out  1  select for High/Low muxes (0 = mult, 1 = div)
//  high_load    out  1  HI register load enable
//  low_load     out  1  LO register load enable
//  busy         out  1  high whenever state != IDLE
//  done         out  1  one-cycle pulse: HI/LO written
//  div0_exc     out  1  one-cycle pulse: divide by zero, HI/LO untouched
//  timeout_exc  out  1  one-cycle pulse: unit never stopped, HI/LO untouched
// BEHAVIOUR
//  - Reset: state IDLE; counter 0; op_r 0; every output 0.
//  - States: IDLE, START, WAIT, WRITE, DONE, EXC_DZ, EXC_TO.
//  - IDLE: op_start=1 -> latch op_r<=op_sel, go START. Otherwise stay.
//  - START: assert mult_init (op_r=0) or div_init (op_r=1) for exactly one
//    cycle. Clear counter. Go WAIT.
//  - WAIT: counter+1 per cycle. Priority per cycle:
//    abort > div_zero (op_r=1 only) > selected stop > counter==TIMEOUT_CYCLES-1.
//    -> IDLE / EXC_DZ / WRITE / EXC_TO respectively.
//  - Stop or div_zero from the non-selected unit is ignored.
//  - WRITE: high_load=low_load=1 for one cycle. Go DONE.
//  - DONE: done=1 for one cycle. Go IDLE.
//  - EXC_DZ / EXC_TO: pulse div0_exc / timeout_exc for one cycle, no loads,
//    go IDLE.
//  - abort in START, WAIT, WRITE, DONE or EXC_*: next state IDLE.
//    No further init/load/done/exc pulses after the abort edge.
//  - Loads already asserted in the abort cycle still occur.
//  - hilo_sel = op_r at all times. Stable from START through DONE.
//  - busy = (state != IDLE). op_start while busy is ignored, not queued.
//  - Latency, op_start sampled at edge 0:
//    - init high during cycle 1.
//    - stop first seen in cycle k -> loads in cycle k+1, done in cycle k+2.
//  - Counter saturates, never wraps; cleared on entry to START.
//  - Async reset mid-operation: immediate return to reset values, no pulses.
//  - All outputs are registered or decoded from state only (no input-to-output
//    combinational path).
// TESTING
//  1. op_start=1, op_sel=0; mult_stop at cycle 34
//     -> mult_init only in cycle 1, hilo_sel=0, loads in 35, done in 36,
//        busy low in 37.
//  2. op_sel=1, div_zero=1 in cycle 3
//     -> div0_exc in cycle 4; high_load/low_load never asserted; done never
//        asserted.
//  3. op_sel=1, stops held 0
//     -> timeout_exc exactly TIMEOUT_CYCLES+2 cycles after op_start; no loads.
//  4. op_sel=0; div_stop=1 and div_zero=1 in WAIT
//     -> ignored; later mult_stop -> normal WRITE/DONE with hilo_sel=0.
//  5. abort in WAIT, same cycle as mult_stop
//     -> IDLE next cycle, no loads or done. New op_start in the following
//        cycle is accepted.
//  6. op_start re-pulsed while busy, then reset asserted mid-WAIT
//     -> second request ignored; all outputs 0 immediately on reset.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Control sequencer for the multi-cycle multiply and divide units.
// Launches one unit, waits for its result or a fault, then loads HI/LO.
module muldiv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic op_start,
  input  logic op_sel,
  input  logic abort,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  output logic mult_init,
  output logic div_init,
  output logic hilo_sel,
  output logic high_load,
  output logic low_load,
  output logic busy,
  output logic done,
  output logic div0_exc,
  output logic timeout_exc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_EXC_DZ,
    S_EXC_TO
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             sel_stop;

  // Only the launched unit may finish the operation.
  assign sel_stop = op_q ? div_stop : mult_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_start) begin
          op_d    = op_sel;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (op_q && div_zero) begin
          state_d = S_EXC_DZ;
        end else if (sel_stop) begin
          state_d = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_EXC_TO;
        end
      end
      S_WRITE: begin
        state_d = abort ? S_IDLE : S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      S_EXC_DZ: state_d = S_IDLE;
      S_EXC_TO: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Every output is a pure decode of registered state.
  assign mult_init   = (state_q == S_START) & ~op_q;
  assign div_init    = (state_q == S_START) &  op_q;
  assign hilo_sel    = op_q;
  assign high_load   = (state_q == S_WRITE);
  assign low_load    = (state_q == S_WRITE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div0_exc    = (state_q == S_EXC_DZ);
  assign timeout_exc = (state_q == S_EXC_TO);

endmodule
